// File: rtl/pa_mc.sv
// Multi-channel, time-interleaved phase accumulator feeding the CORDIC/ROM NCO stage.
// One channel slot is processed per enabled cycle in round-robin order.
module pa_mc #(
   parameter int unsigned AccW = 24,
   parameter int unsigned OutW = 16,
   parameter int unsigned Ch   = 4,
   localparam int unsigned ChW = $clog2(Ch)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   input  logic            sync_i,
   input  logic            cfg_we_i,
   input  logic [ChW-1:0]  cfg_ch_i,
   input  logic [AccW-1:0] cfg_fcw_i,
   input  logic [OutW-1:0] cfg_off_i,
   input  logic            upd_i,
   input  logic            tag_i,
   output logic            valid_o,
   output logic [OutW-1:0] phase_o,
   output logic [ChW-1:0]  ch_o,
   output logic            wrap_o,
   output logic            tag_o
);

   logic [AccW-1:0] acc_q   [Ch];
   logic [AccW-1:0] acc_d   [Ch];
   logic [AccW-1:0] fcw_s_q [Ch];
   logic [AccW-1:0] fcw_s_d [Ch];
   logic [OutW-1:0] off_s_q [Ch];
   logic [OutW-1:0] off_s_d [Ch];
   logic [AccW-1:0] fcw_a_q [Ch];
   logic [AccW-1:0] fcw_a_d [Ch];
   logic [OutW-1:0] off_a_q [Ch];
   logic [OutW-1:0] off_a_d [Ch];

   logic [ChW-1:0]  slot_q, slot_d;
   logic            valid_q, valid_d;
   logic [OutW-1:0] phase_q, phase_d;
   logic [ChW-1:0]  ch_q, ch_d;
   logic            wrap_q, wrap_d;
   logic            tag_q;

   logic [AccW:0]   acc_sum;
   logic [AccW-1:0] off_ext;
   logic [AccW-1:0] phase_sum;

   // Extra MSB of the sum captures the accumulator carry-out.
   assign acc_sum   = {1'b0, acc_q[slot_q]} + {1'b0, fcw_a_q[slot_q]};
   assign off_ext   = AccW'(off_a_q[slot_q]) << (AccW - OutW);
   assign phase_sum = acc_q[slot_q] + off_ext;

   always_comb begin
      acc_d   = acc_q;
      fcw_s_d = fcw_s_q;
      off_s_d = off_s_q;
      fcw_a_d = fcw_a_q;
      off_a_d = off_a_q;
      slot_d  = slot_q;
      valid_d = 1'b0;
      phase_d = phase_q;
      ch_d    = ch_q;
      wrap_d  = wrap_q;

      if (sync_i) begin
         for (int unsigned c = 0; c < Ch; c++) begin
            acc_d[c] = '0;
         end
         slot_d = '0;
         wrap_d = 1'b0;
      end else if (en_i) begin
         acc_d[slot_q] = acc_sum[AccW-1:0];
         wrap_d        = acc_sum[AccW];
         phase_d       = phase_sum[AccW-1 -: OutW];
         ch_d          = slot_q;
         valid_d       = 1'b1;
         slot_d        = slot_q + ChW'(1);
      end

      if (cfg_we_i) begin
         fcw_s_d[cfg_ch_i] = cfg_fcw_i;
         off_s_d[cfg_ch_i] = cfg_off_i;
      end

      // Copy from the next-state shadow so a same-cycle write goes straight through.
      if (upd_i) begin
         fcw_a_d = fcw_s_d;
         off_a_d = off_s_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q   <= '{default: '0};
         fcw_s_q <= '{default: '0};
         off_s_q <= '{default: '0};
         fcw_a_q <= '{default: '0};
         off_a_q <= '{default: '0};
         slot_q  <= '0;
         valid_q <= 1'b0;
         phase_q <= '0;
         ch_q    <= '0;
         wrap_q  <= 1'b0;
         tag_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         fcw_s_q <= fcw_s_d;
         off_s_q <= off_s_d;
         fcw_a_q <= fcw_a_d;
         off_a_q <= off_a_d;
         slot_q  <= slot_d;
         valid_q <= valid_d;
         phase_q <= phase_d;
         ch_q    <= ch_d;
         wrap_q  <= wrap_d;
         tag_q   <= tag_i;
      end
   end

   assign valid_o = valid_q;
   assign phase_o = phase_q;
   assign ch_o    = ch_q;
   assign wrap_o  = wrap_q;
   assign tag_o   = tag_q;

endmodule

// File: tb/tb_pa_mc.sv
// Self-checking bench for pa_mc: directed scenarios plus randomized traffic against a
// cycle-level arithmetic model of the channel accumulators.
module tb_pa_mc;

   localparam int    CH = 4;
   localparam longint M = 64'd1 << 24;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i, sync_i, cfg_we_i, upd_i, tag_i;
   logic [1:0]  cfg_ch_i;
   logic [23:0] cfg_fcw_i;
   logic [15:0] cfg_off_i;
   logic        valid_o, wrap_o, tag_o;
   logic [15:0] phase_o;
   logic [1:0]  ch_o;

   int n_checks = 0;
   int n_pass   = 0;

   longint m_acc [CH], m_fcw_s [CH], m_off_s [CH], m_fcw_a [CH], m_off_a [CH];
   int     m_slot, m_ch;
   longint m_phase;
   bit     m_valid, m_wrap, m_tag;

   pa_mc dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .sync_i    (sync_i),
      .cfg_we_i  (cfg_we_i),
      .cfg_ch_i  (cfg_ch_i),
      .cfg_fcw_i (cfg_fcw_i),
      .cfg_off_i (cfg_off_i),
      .upd_i     (upd_i),
      .tag_i     (tag_i),
      .valid_o   (valid_o),
      .phase_o   (phase_o),
      .ch_o      (ch_o),
      .wrap_o    (wrap_o),
      .tag_o     (tag_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_acc[c] = 0; m_fcw_s[c] = 0; m_off_s[c] = 0; m_fcw_a[c] = 0; m_off_a[c] = 0;
      end
      m_slot = 0; m_ch = 0; m_phase = 0; m_valid = 0; m_wrap = 0; m_tag = 0;
   endtask

   task automatic clr_inputs();
      en_i = 0; sync_i = 0; cfg_we_i = 0; upd_i = 0; tag_i = 0;
      cfg_ch_i = 0; cfg_fcw_i = 0; cfg_off_i = 0;
   endtask

   // Advance one clock and apply the behavioural rules to the model using the sampled inputs.
   task automatic step();
      longint sum;
      int     s;
      @(posedge clk_i);
      if (sync_i) begin
         for (int c = 0; c < CH; c++) m_acc[c] = 0;
         m_slot = 0; m_valid = 0; m_wrap = 0;
      end else if (en_i) begin
         s       = m_slot;
         sum     = m_acc[s] + m_fcw_a[s];
         m_wrap  = (sum >= M);
         m_phase = ((m_acc[s] + m_off_a[s] * 256) % M) / 256;
         m_acc[s] = sum % M;
         m_ch    = s;
         m_valid = 1;
         m_slot  = (s + 1) % CH;
      end else begin
         m_valid = 0;
      end
      if (cfg_we_i) begin
         m_fcw_s[cfg_ch_i] = cfg_fcw_i;
         m_off_s[cfg_ch_i] = cfg_off_i;
      end
      if (upd_i) begin
         for (int c = 0; c < CH; c++) begin
            m_fcw_a[c] = m_fcw_s[c];
            m_off_a[c] = m_off_s[c];
         end
      end
      m_tag = tag_i;
      #1;
   endtask

   task automatic cfg(input int ch, input longint fcw, input longint off);
      cfg_we_i = 1; cfg_ch_i = 2'(ch); cfg_fcw_i = 24'(fcw); cfg_off_i = 16'(off);
      step();
      cfg_we_i = 0;
   endtask

   task automatic pulse_upd();
      upd_i = 1; step(); upd_i = 0;
   endtask

   task automatic pulse_sync();
      sync_i = 1; step(); sync_i = 0;
   endtask

   task automatic test_reset();
      rst_ni = 0;
      clr_inputs();
      model_reset();
      #1;
      n_checks++;
      if ({valid_o, phase_o, ch_o, wrap_o, tag_o} !== 21'd0)
         $display("FAIL reset_outputs: got v=%0b ph=%h ch=%0d w=%0b t=%0b want all 0",
                  valid_o, phase_o, ch_o, wrap_o, tag_o);
      else n_pass++;
      #7 rst_ni = 1;
      step();
      n_checks++;
      if (valid_o !== 1'b0) $display("FAIL reset_idle_valid: got %0b want 0", valid_o);
      else n_pass++;
   endtask

   task automatic test_fcw_stepping();
      int k0 = 0;
      cfg(0, 'h100000, 0);
      pulse_upd();
      en_i = 1;
      for (int i = 0; i < 16; i++) begin
         step();
         n_checks++;
         if ({valid_o, phase_o, ch_o, wrap_o, tag_o} !==
             {m_valid, m_phase[15:0], m_ch[1:0], m_wrap, m_tag})
            $display("FAIL fcw_model: got v=%0b ph=%h ch=%0d w=%0b want v=%0b ph=%h ch=%0d w=%0b",
                     valid_o, phase_o, ch_o, wrap_o, m_valid, m_phase[15:0], m_ch, m_wrap);
         else n_pass++;
         n_checks++;
         if (ch_o == 2'd0) begin
            if (phase_o !== 16'(k0 * 'h1000))
               $display("FAIL fcw_ch0_phase: got %h want %h", phase_o, 16'(k0 * 'h1000));
            else n_pass++;
            k0++;
         end else begin
            if (phase_o !== 16'h0000) $display("FAIL fcw_other_phase: got %h want 0000", phase_o);
            else n_pass++;
         end
      end
      en_i = 0;
   endtask

   task automatic test_overflow();
      int k1 = 0;
      cfg(1, 'h400000, 0);
      pulse_upd();
      pulse_sync();
      en_i = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if ({valid_o, phase_o, ch_o, wrap_o} !== {m_valid, m_phase[15:0], m_ch[1:0], m_wrap})
            $display("FAIL ovf_model: got ph=%h ch=%0d w=%0b want ph=%h ch=%0d w=%0b",
                     phase_o, ch_o, wrap_o, m_phase[15:0], m_ch, m_wrap);
         else n_pass++;
         n_checks++;
         if (ch_o == 2'd1) begin
            if ({phase_o, wrap_o} !== {16'(k1 * 'h4000), 1'(k1 == 3)})
               $display("FAIL ovf_ch1: got ph=%h w=%0b want ph=%h w=%0b",
                        phase_o, wrap_o, 16'(k1 * 'h4000), k1 == 3);
            else n_pass++;
            k1++;
         end else begin
            if (wrap_o !== 1'b0) $display("FAIL ovf_other_wrap: got %0b want 0", wrap_o);
            else n_pass++;
         end
      end
      en_i = 0;
   endtask

   task automatic test_offset();
      int k2;
      for (int pass = 0; pass < 2; pass++) begin
         cfg(2, (pass == 0) ? 0 : 'h800000, 'h8000);
         pulse_upd();
         pulse_sync();
         en_i = 1;
         k2 = 0;
         for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({valid_o, phase_o, ch_o, wrap_o} !== {m_valid, m_phase[15:0], m_ch[1:0], m_wrap})
               $display("FAIL off_model: got ph=%h ch=%0d w=%0b want ph=%h ch=%0d w=%0b",
                        phase_o, ch_o, wrap_o, m_phase[15:0], m_ch, m_wrap);
            else n_pass++;
            if (ch_o == 2'd2) begin
               n_checks++;
               if (phase_o !== ((pass == 1 && k2 % 2 == 1) ? 16'h0000 : 16'h8000))
                  $display("FAIL off_ch2: got %h pass %0d idx %0d", phase_o, pass, k2);
               else n_pass++;
               k2++;
            end
         end
         en_i = 0;
      end
   endtask

   task automatic test_shadow();
      logic [15:0] exp0 [5] = '{16'h0000, 16'h1000, 16'h2000, 16'h4000, 16'h6000};
      int k = 0;
      int k3 = 0;
      cfg(0, 'h200000, 0);
      pulse_sync();
      en_i = 1;
      for (int i = 0; i < 17; i++) begin
         upd_i = (i == 4);
         step();
         n_checks++;
         if ({valid_o, phase_o, ch_o, wrap_o} !== {m_valid, m_phase[15:0], m_ch[1:0], m_wrap})
            $display("FAIL shadow_model: got ph=%h ch=%0d want ph=%h ch=%0d",
                     phase_o, ch_o, m_phase[15:0], m_ch);
         else n_pass++;
         if (ch_o == 2'd0 && k < 5) begin
            n_checks++;
            if (phase_o !== exp0[k]) $display("FAIL shadow_ch0: got %h want %h", phase_o, exp0[k]);
            else n_pass++;
            k++;
         end
      end
      upd_i = 0; en_i = 0;
      // Same-cycle write and update: new FCW must be active immediately.
      cfg_we_i = 1; upd_i = 1; cfg_ch_i = 2'd3; cfg_fcw_i = 24'h010000; cfg_off_i = 16'h0;
      step();
      cfg_we_i = 0; upd_i = 0;
      pulse_sync();
      en_i = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (ch_o == 2'd3) begin
            n_checks++;
            if (phase_o !== 16'(k3 * 'h0100))
               $display("FAIL writethrough_ch3: got %h want %h", phase_o, 16'(k3 * 'h0100));
            else n_pass++;
            k3++;
         end
      end
      en_i = 0;
   endtask

   task automatic test_sync();
      cfg(0, 'h100000, 'h1234);
      pulse_upd();
      pulse_sync();
      en_i = 1;
      repeat (6) step();
      sync_i = 1;
      step();
      sync_i = 0;
      n_checks++;
      if (valid_o !== 1'b0) $display("FAIL sync_valid: got %0b want 0", valid_o);
      else n_pass++;
      step();
      n_checks++;
      if ({valid_o, ch_o, phase_o} !== {1'b1, 2'd0, 16'h1234})
         $display("FAIL sync_first: got v=%0b ch=%0d ph=%h want v=1 ch=0 ph=1234",
                  valid_o, ch_o, phase_o);
      else n_pass++;
      repeat (4) step();
      n_checks++;
      if ({ch_o, phase_o, m_phase[15:0]} !== {2'd0, 16'h2234, 16'h2234})
         $display("FAIL sync_fcw_kept: got ch=%0d ph=%h want ch=0 ph=2234", ch_o, phase_o);
      else n_pass++;
      en_i = 0;
   endtask

   task automatic test_async_reset();
      logic prev_tag;
      en_i = 1; tag_i = 1;
      repeat (5) step();
      #2 rst_ni = 0;
      model_reset();
      #1;
      n_checks++;
      if ({valid_o, phase_o, ch_o, wrap_o, tag_o} !== 21'd0)
         $display("FAIL async_reset: got v=%0b ph=%h ch=%0d w=%0b t=%0b want all 0",
                  valid_o, phase_o, ch_o, wrap_o, tag_o);
      else n_pass++;
      #2 rst_ni = 1;
      tag_i = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if ({valid_o, phase_o, wrap_o} !== {1'b1, 16'h0000, 1'b0})
            $display("FAIL post_reset_zero: got v=%0b ph=%h w=%0b want v=1 ph=0000 w=0",
                     valid_o, phase_o, wrap_o);
         else n_pass++;
      end
      prev_tag = 0;
      for (int i = 0; i < 24; i++) begin
         tag_i = 1'($urandom);
         en_i  = 1'($urandom);
         prev_tag = tag_i;
         step();
         n_checks++;
         if (tag_o !== prev_tag) $display("FAIL tag_delay: got %0b want %0b", tag_o, prev_tag);
         else n_pass++;
      end
      clr_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en_i      = ($urandom_range(0, 3) != 0);
         sync_i    = ($urandom_range(0, 31) == 0);
         cfg_we_i  = ($urandom_range(0, 3) == 0);
         upd_i     = ($urandom_range(0, 7) == 0);
         tag_i     = 1'($urandom);
         cfg_ch_i  = 2'($urandom);
         cfg_fcw_i = 24'($urandom);
         cfg_off_i = 16'($urandom);
         step();
         n_checks++;
         if ({valid_o, phase_o, ch_o, wrap_o, tag_o} !==
             {m_valid, m_phase[15:0], m_ch[1:0], m_wrap, m_tag})
            $display("FAIL random_model @%0d: got v=%0b ph=%h ch=%0d w=%0b t=%0b want v=%0b ph=%h ch=%0d w=%0b t=%0b",
                     i, valid_o, phase_o, ch_o, wrap_o, tag_o,
                     m_valid, m_phase[15:0], m_ch, m_wrap, m_tag);
         else n_pass++;
      end
      clr_inputs();
   endtask

   initial begin
      test_reset();
      test_fcw_stepping();
      test_overflow();
      test_offset();
      test_shadow();
      test_sync();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pa_mc.md
# pa_mc

Parametrised, multi-channel phase accumulator for the CORDIC/ROM NCO path. A single time-interleaved accumulator core serves CH independent channels in round-robin order. Each channel has a shadow-buffered frequency control word and a phase offset. The block emits one truncated phase word per enabled cycle, tagged with its channel index, to the downstream CORDIC/ROM stage. It also supports a coherent all-channel restart and a latency-matched sideband pass-through.

## Interface
- ACC_W, 24, accumulator width in bits (≥ OUT_W)
- OUT_W, 16, output phase width; phase = top OUT_W bits of accumulator
- CH, 4, channel count, power of two ≥ 2; CH_W = log2(CH)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  process one channel slot this cycle
- sync  in  1  synchronous restart of all channels
- cfg_we  in  1  write shadow FCW/offset of channel cfg_ch
- cfg_ch  in  CH_W  channel index for cfg_we
- cfg_fcw  in  ACC_W  frequency control word
- cfg_off  in  OUT_W  phase offset
- upd  in  1  copy all shadow registers to active registers
- tag_in  in  1  sideband bit
- valid  out  1  phase/ch_out/wrap are valid
- phase  out  OUT_W  offset-adjusted phase
- ch_out  out  CH_W  channel index of phase
- wrap  out  1  accumulator overflowed on this update
- tag_out  out  1  tag_in delayed by one cycle

## Operation
- Per-channel state:
  - accumulator acc[c] (ACC_W)
  - shadow fcw_s[c] and off_s[c]
  - active fcw_a[c] and off_a[c]
- Global state: slot counter slot (CH_W).
- Slot processing (en=1, sync=0), with s = slot:
  - acc[s] <= (acc[s] + fcw_a[s]) mod 2^ACC_W
  - wrap <= carry out of that sum
  - phase <= top OUT_W bits of (acc[s] + (off_a[s] << (ACC_W−OUT_W))) mod 2^ACC_W. This uses the pre-update acc[s], so each channel's first output after restart equals its offset.
  - ch_out <= s; valid <= 1; slot <= (s+1) mod CH.
- en=0:
  - valid <= 0. No accumulator or slot change.
  - phase, ch_out and wrap hold their last values.
- sync=1 (priority over en):
  - all acc[c] <= 0; slot <= 0; valid <= 0; wrap <= 0.
  - Active and shadow registers are unchanged.
- cfg_we=1: fcw_s[cfg_ch] <= cfg_fcw; off_s[cfg_ch] <= cfg_off. Active registers are not affected.
- upd=1: for all c, fcw_a[c] <= fcw_s[c] and off_a[c] <= off_s[c].
  - If cfg_we and upd occur in the same cycle, the newly written value reaches the active register of cfg_ch in that same cycle (write-through).
- upd, cfg_we and sync are independent; any combination in one cycle is legal and applies all effects.
- tag_out <= tag_in every cycle, regardless of en/sync.

## Timing
- Latency: one cycle from the en sampling edge to valid/phase/ch_out/wrap.
- Throughput: one channel per enabled cycle; each channel is updated every CH enabled cycles.
- A slot processed in the same cycle as upd uses the old active FCW/offset. The new values take effect from the next cycle.
- A slot processed in the same cycle as sync is discarded. The next enabled cycle processes slot 0 with acc=0.
- Reset (asynchronous, active-low): all accumulators, shadow and active registers, slot, valid, phase, ch_out, wrap and tag_out go to 0 immediately. Reset asserted mid-run discards all in-flight state.
- Wrap-around: accumulator and offset additions are modulo 2^ACC_W. No saturation.

## Test plan
- **FCW stepping.** Setup: reset; cfg ch0 fcw=0x100000; upd; en=1 continuously. Required: ch0 outputs appear every 4th valid cycle with phase 0x0000, 0x1000, 0x2000, …; ch1–3 output phase 0x0000.
- **Overflow.** Setup: ch1 fcw=0x400000. Required: ch1 phases 0x0000, 0x4000, 0x8000, 0xC000, 0x0000; wrap=1 only on the 4th ch1 update (the output showing 0xC000); wrap=0 on all other outputs.
- **Offset and modulo addition.** Setup: ch2 off=0x8000, fcw=0. Required: ch2 phase is always 0x8000. Then set fcw=0x800000 and upd. Required: ch2 phases alternate 0x8000, 0x0000, 0x8000 (offset wraps modulo).
- **Shadow buffering.** Setup: cfg_we ch0 fcw=0x200000 without upd. Required: ch0 step stays 0x1000. Then assert upd together with en. Required: the slot in that cycle uses the old FCW; ch0 step becomes 0x2000 from the next ch0 update. Also check cfg_we and upd in the same cycle: the new value is active.
- **Coherent restart.** Stimulus: sync=1 with en=1 mid-stream. Required: valid=0 on the next cycle; the next valid output has ch_out=0 and phase=off_a[0]; FCW settings are retained.
- **Asynchronous reset.** Stimulus: drop reset between clock edges. Required: valid, phase, ch_out, wrap and tag_out are all 0 before the next edge. After release, all channels output 0 until they are reconfigured. Also check that tag_out follows tag_in with one cycle of delay independent of en.
